// File: rtl/led_pkg.sv
// Shared types and default timing for the LED pulse-code arbiter.
// Holds the FSM state enum and the default tick/phase constants.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ON   = 3'd1,
        ST_OFF  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } led_state_e;

    localparam int DEF_TICK_DIV  = 50_000;
    localparam int DEF_ON_TICKS  = 200;
    localparam int DEF_OFF_TICKS = 200;
    localparam int DEF_GAP_TICKS = 1000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_DIV clocks while i_clear is low.
// i_clear holds the count at 0 so the first tick lands TICK_DIV cycles after release.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/led_code_arbiter.sv
// Arbitrates NREQ requesters and blinks each winner's code as LED pulses, then acks it.
// Define LED_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module led_code_arbiter
    import led_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int CODE_W    = 4,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int GAP_TICKS = DEF_GAP_TICKS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CODE_W-1:0]  code,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    led
);

    localparam int ID_W = $clog2(NREQ);
    localparam int PH_W = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);

    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);

    if ((NREQ < 2) || (TICK_DIV < 1) || (ON_TICKS < 1) || (OFF_TICKS < 1) || (GAP_TICKS < 1)) begin : g_bad_params
        $error("led_code_arbiter: NREQ must be >= 2 and TICK_DIV/ON/OFF/GAP_TICKS >= 1");
    end

    led_state_e        r_state, w_state_nxt;
    logic [PH_W-1:0]   r_phase_cnt, w_phase_nxt, w_phase_last;
    logic [CODE_W-1:0] r_pulses, w_pulses_nxt;
    logic [ID_W-1:0]   r_grant_id, w_grant_nxt;
    logic [NREQ-1:0]   r_ack, w_ack_vec;
    logic              r_led;
    logic              w_tick, w_tick_clr, w_phase_end;
    logic [ID_W-1:0]   w_winner;
    logic [CODE_W-1:0] w_win_code;

    assign w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_DONE);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_tick_clr),
        .o_tick  (w_tick)
    );

`ifdef LED_ARB_RR_EN
    logic [ID_W-1:0] r_rr_ptr;
    logic            w_found;

    // Search starts one past the last winner, wrapping at NREQ.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if ((r_state == ST_IDLE) && (|req)) begin
            r_rr_ptr <= (w_winner == ID_W'(NREQ - 1)) ? '0 : w_winner + ID_W'(1);
        end
    end
`else
    always_comb begin
        w_winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) w_winner = ID_W'(i);
        end
    end
`endif

    assign w_win_code = code[int'(w_winner)*CODE_W +: CODE_W];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase_cnt;
        w_pulses_nxt = r_pulses;
        w_grant_nxt  = r_grant_id;

        case (r_state)
            ST_ON:   w_phase_last = ON_LAST;
            ST_OFF:  w_phase_last = OFF_LAST;
            ST_GAP:  w_phase_last = GAP_LAST;
            default: w_phase_last = '0;
        endcase

        w_phase_end = w_tick && (r_phase_cnt == w_phase_last);
        if (w_tick) begin
            w_phase_nxt = w_phase_end ? '0 : r_phase_cnt + PH_W'(1);
        end

        unique case (r_state)
            ST_IDLE: begin
                w_phase_nxt = '0;
                if (|req) begin
                    w_grant_nxt  = w_winner;
                    w_pulses_nxt = w_win_code;
                    w_state_nxt  = (w_win_code != '0) ? ST_ON : ST_GAP;
                end
            end
            ST_ON: begin
                if (w_phase_end) w_state_nxt = ST_OFF;
            end
            ST_OFF: begin
                // The pulse just finished is retired here; the last one leads into the gap.
                if (w_phase_end) begin
                    w_pulses_nxt = r_pulses - CODE_W'(1);
                    w_state_nxt  = (r_pulses == CODE_W'(1)) ? ST_GAP : ST_ON;
                end
            end
            ST_GAP: begin
                if (w_phase_end) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_ack_vec = {{(NREQ-1){1'b0}}, 1'b1} << w_grant_nxt;
    end

    // led and ack are registered from the next state so they align exactly with ON/DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_phase_cnt <= '0;
            r_pulses    <= '0;
            r_grant_id  <= '0;
            r_led       <= 1'b0;
            r_ack       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase_cnt <= w_phase_nxt;
            r_pulses    <= w_pulses_nxt;
            r_grant_id  <= w_grant_nxt;
            r_led       <= (w_state_nxt == ST_ON);
            r_ack       <= (w_state_nxt == ST_DONE) ? w_ack_vec : '0;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant_id;
    assign led      = r_led;
    assign ack      = r_ack;

endmodule

// File: tb/tb_led_code_arbiter.sv
// Self-checking bench for led_code_arbiter: vector table, corner sequences and random traffic
// compared every cycle against a schedule-queue model of the blink protocol.
module tb_led_code_arbiter;

    localparam int NREQ     = 4;
    localparam int CODE_W   = 4;
    localparam int TICK_DIV = 2;
    localparam int ON_T     = 3;
    localparam int OFF_T    = 2;
    localparam int GAP_T    = 4;
    localparam int ON_LEN   = ON_T * TICK_DIV;
    localparam int OFF_LEN  = OFF_T * TICK_DIV;
    localparam int GAP_LEN  = GAP_T * TICK_DIV;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*CODE_W-1:0] code;
    logic [NREQ-1:0]        ack;
    logic                   busy;
    logic [1:0]             grant_id;
    logic                   led;

    led_code_arbiter #(
        .NREQ      (NREQ),
        .CODE_W    (CODE_W),
        .TICK_DIV  (TICK_DIV),
        .ON_TICKS  (ON_T),
        .OFF_TICKS (OFF_T),
        .GAP_TICKS (GAP_T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .code     (code),
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue holding the expected {led, ack} of each remaining busy cycle.
    typedef struct {
        bit led;
        bit ack;
    } slot_t;

    slot_t m_sched[$];
    int    m_grant;
    int    m_ptr;

    logic       obs_led;
    logic       obs_busy;
    logic [3:0] obs_ack;
    int         obs_grant;

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
`ifdef LED_ARB_RR_EN
        for (int k = 0; k < NREQ; k++) if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_sched.delete();
        m_grant = 0;
        m_ptr   = 0;
    endtask

    task automatic model_grant();
        int    w;
        int    c;
        slot_t s;
        w       = pick(req, m_ptr);
        m_grant = w;
        m_ptr   = (w + 1) % NREQ;
        c       = int'(code[w*CODE_W +: CODE_W]);
        for (int p = 0; p < c; p++) begin
            s = '{led: 1'b1, ack: 1'b0};
            repeat (ON_LEN) m_sched.push_back(s);
            s = '{led: 1'b0, ack: 1'b0};
            repeat (OFF_LEN) m_sched.push_back(s);
        end
        s = '{led: 1'b0, ack: 1'b0};
        repeat (GAP_LEN) m_sched.push_back(s);
        s = '{led: 1'b0, ack: 1'b1};
        m_sched.push_back(s);
    endtask

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic       exp_busy;
        logic       exp_led;
        logic [3:0] exp_ack;
        @(negedge clk);
        exp_busy  = (m_sched.size() != 0);
        exp_led   = exp_busy ? m_sched[0].led : 1'b0;
        exp_ack   = (exp_busy && m_sched[0].ack) ? (4'b0001 << m_grant) : 4'b0000;
        obs_led   = led;
        obs_busy  = busy;
        obs_ack   = ack;
        obs_grant = int'(grant_id);
        check("led", led, exp_led);
        check("busy", busy, exp_busy);
        check("ack", ack, exp_ack);
        check("grant_id", grant_id, m_grant);
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (m_sched.size() != 0) void'(m_sched.pop_front());
        else if (req != '0) model_grant();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // Runs one transaction from its grant cycle (k=0) to the ack; optionally drops req/scrambles code at k=drop_at.
    task automatic run_txn(input int budget, input int drop_at,
                           output int ack_at, output int led_cnt, output int gid);
        ack_at  = -1;
        led_cnt = 0;
        gid     = -1;
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (obs_led === 1'b1) led_cnt++;
            if (k == drop_at) begin
                req  = '0;
                code = '1;
            end
            if (obs_ack !== 4'b0000) begin
                ack_at = k;
                gid    = obs_grant;
                break;
            end
        end
        check("txn_ack_seen", (ack_at >= 0), 1'b1);
    endtask

    typedef struct {
        logic [NREQ-1:0]        req;
        logic [NREQ*CODE_W-1:0] code;
        int                     exp_grant;
        int                     exp_led;
        int                     exp_ack_at;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ack_at;
        int led_cnt;
        int gid;
        int exp_a[4];
        int exp_b[5];

        // ack lands at code*(ON_LEN+OFF_LEN) + GAP_LEN + 1 cycles after the grant cycle.
        vecs[0] = '{4'b0010, 16'h0030, 1, 18, 39};
        vecs[1] = '{4'b0100, 16'h0000, 2, 0, 9};
        vecs[2] = '{4'b1000, 16'h2000, 3, 12, 29};
        vecs[3] = '{4'b0001, 16'h000F, 0, 90, 159};
        vecs[4] = '{4'b0110, 16'h0510, 1, 6, 19};
        vecs[5] = '{4'b1100, 16'h1200, 2, 12, 29};
        exp_a = '{0, 1, 2, 3};
`ifdef LED_ARB_RR_EN
        exp_b = '{0, 1, 2, 3, 0};
`else
        exp_b = '{0, 0, 0, 0, 0};
`endif

        req  = '0;
        code = '0;
        do_reset();

        foreach (vecs[i]) begin
            req  = vecs[i].req;
            code = vecs[i].code;
            run_txn(400, -1, ack_at, led_cnt, gid);
            req = '0;
            check($sformatf("vec%0d_grant", i), gid, vecs[i].exp_grant);
            check($sformatf("vec%0d_led_cycles", i), led_cnt, vecs[i].exp_led);
            check($sformatf("vec%0d_ack_cycle", i), ack_at, vecs[i].exp_ack_at);
        end

        // All four request; each drops after its own ack.
        do_reset();
        req  = 4'b1111;
        code = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            run_txn(100, -1, ack_at, led_cnt, gid);
            check($sformatf("order_a%0d", i), gid, exp_a[i]);
            if (gid >= 0) req[gid] = 1'b0;
        end

        // Requester 0 keeps re-raising its request.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_txn(100, -1, ack_at, led_cnt, gid);
            check($sformatf("order_b%0d", i), gid, exp_b[i]);
            if (gid >= 0) req[gid] = 1'b0;
            req[0] = 1'b1;
        end
        req = '0;

        // Reset during the second ON phase, then a clean replay.
        do_reset();
        req  = 4'b0010;
        code = 16'h0030;
        repeat (13) cycle();
        check("pre_reset_led", led, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_led", led, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ack", ack, 4'b0000);
        check("rst_grant", grant_id, 2'd0);
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        run_txn(400, -1, ack_at, led_cnt, gid);
        req = '0;
        check("replay_grant", gid, 1);
        check("replay_led_cycles", led_cnt, 18);
        check("replay_ack_cycle", ack_at, 39);

        // Request withdrawn two cycles after the grant; sequence must still complete.
        req  = 4'b1000;
        code = 16'h2000;
        run_txn(400, 2, ack_at, led_cnt, gid);
        req = '0;
        check("drop_grant", gid, 3);
        check("drop_led_cycles", led_cnt, 12);
        check("drop_ack_cycle", ack_at, 29);

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            code = NREQ*CODE_W'($urandom) & 16'h3333;
            if (obs_ack !== 4'b0000) req = req & ~obs_ack;
            if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 3)] = 1'b1;
            cycle();
        end

        req = '0;
        for (int n = 0; n < 300; n++) begin
            if (m_sched.size() == 0) break;
            cycle();
        end
        cycle();
        check("drain_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
